// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a FIFO of FIFO_DEPTH characters; first start bit appears two edges after the pop.
// Writes are accepted while not full; a write into a full FIFO is dropped and flagged by a one-cycle overflow pulse.
module uart_tx_fifo #(
  parameter int INPUT_CLK  = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               wr_en,
  input  logic [DATA_BITS-1:0]               wr_data,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow,
  output logic                               tx_busy,
  output logic                               tx
);

  localparam int CLKS_PER_BIT = INPUT_CLK / BAUD_RATE;
  localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
  localparam int CNT_W        = $clog2(STOP_CLKS + 1);
  localparam int BIT_W        = $clog2(DATA_BITS + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int FCNT_W       = $clog2(FIFO_DEPTH + 1);

  localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_CLKS - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [FCNT_W-1:0]    count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 ovf_q, ovf_d;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;

  logic                 wr_acc;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    head    = mem_q[rd_ptr_q];
    unique case (state_q)
      S_IDLE: begin
        if (!empty_q) begin
          pop     = 1'b1;
          state_d = S_START;
          baud_d  = '0;
        end
      end
      S_START: begin
        if (baud_q == BIT_LAST) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_q == BIT_LAST) begin
          state_d = S_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        // Chain straight into the next start bit so queued frames have no idle gap.
        if (baud_q == STOP_LAST) begin
          baud_d = '0;
          if (!empty_q) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (pop) begin
      shift_d = head;
      par_d   = (PARITY == 1) ? ~^head : ^head;
    end
  end

  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
      S_PARITY: tx_d = par_q;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_q != S_IDLE);
  end

  always_comb begin
    wr_acc   = wr_en && !full_q;
    wr_ptr_d = wr_acc ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + FCNT_W'(wr_acc) - FCNT_W'(pop);
    full_d   = (count_d == FCNT_W'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
    ovf_d    = wr_en && full_q;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign full       = full_q;
  assign empty      = empty_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;
  assign tx_busy    = busy_q;
  assign tx         = tx_q;

endmodule
